// File: rtl/fiesta_rng_pkg.sv
// Shared types and default constants for the fiesta
// fresh-randomness source and its LFSR helper.
package fiesta_rng_pkg;

  typedef enum logic [1:0] {
    UNSEEDED,
    RUN,
    RESEED,
    ERR
  } rng_state_e;

  localparam int          DEF_LFSR_WIDTH      = 32;
  localparam int          DEF_R_WIDTH         = 2;
  localparam logic [31:0] DEF_TAPS            = 32'h80200003;
  localparam int          DEF_RESEED_INTERVAL = 1024;
  localparam int          DEF_REP_LIMIT       = 16;

endpackage

// File: rtl/fiesta_lfsr_step.sv
// Combinational N-step Galois LFSR advance; bit i is the
// shifted-out LSB of step i.
module fiesta_lfsr_step #(
  parameter int W = 32,
  parameter int N = 2
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] taps,
  output logic [W-1:0] s_next,
  output logic [N-1:0] bits
);

  logic [W-1:0] t;

  always_comb begin
    t    = s;
    bits = '0;
    for (int i = 0; i < N; i++) begin
      bits[i] = t[0];
      t = (t >> 1) ^ (t[0] ? taps : '0);
    end
    s_next = t;
  end

endmodule

// File: rtl/fiesta_rand_src.sv
// Seeded LFSR randomness source with reseed budget and a
// repetition health test; all outputs except seed_ready registered.
module fiesta_rand_src
  import fiesta_rng_pkg::*;
#(
  parameter int LFSR_WIDTH = DEF_LFSR_WIDTH,
  parameter int R_WIDTH    = DEF_R_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] TAPS =
    LFSR_WIDTH'(DEF_TAPS),
  parameter int RESEED_INTERVAL = DEF_RESEED_INTERVAL,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LFSR_WIDTH-1:0] seed_data,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic                  enable,
  output logic [R_WIDTH-1:0]    port_r,
  output logic                  r_valid,
  output logic                  reseed_req,
  output logic                  seed_rej,
  output logic                  rng_err
);

  localparam int CW = $clog2(RESEED_INTERVAL + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  rng_state_e state_q, state_d;

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic [R_WIDTH-1:0]    port_q, port_d;
  logic                  rv_q, rv_d;
  logic                  rr_q, rr_d;
  logic                  rej_q, rej_d;
  logic                  err_q, err_d;

  logic [LFSR_WIDTH-1:0] s_adv;
  logic [R_WIDTH-1:0]    bits_adv;
  logic [LFSR_WIDTH-1:0] seed_mix;
  logic [RW-1:0]         rep_inc;
  logic                  hs;
  logic                  seed_ok;
  logic                  rep_hit;
  logic                  wrap;

  fiesta_lfsr_step #(
    .W (LFSR_WIDTH),
    .N (R_WIDTH)
  ) u_step (
    .s      (lfsr_q),
    .taps   (TAPS),
    .s_next (s_adv),
    .bits   (bits_adv)
  );

  // A reseed mixes into the running state instead of replacing it.
  assign seed_mix = (state_q == RESEED) ?
                    (lfsr_q ^ seed_data) : seed_data;
  assign seed_ok  = |seed_mix;
  assign hs       = seed_valid & seed_ready;

  assign rep_inc = (bits_adv != port_q) ? RW'(1) :
                   (&rep_q) ? rep_q : rep_q + RW'(1);
  assign rep_hit = rep_inc >= RW'(REP_LIMIT);
  assign wrap    = (cnt_q + CW'(1)) == CW'(RESEED_INTERVAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UNSEEDED;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      port_q  <= '0;
      rv_q    <= 1'b0;
      rr_q    <= 1'b0;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      port_q  <= port_d;
      rv_q    <= rv_d;
      rr_q    <= rr_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNSEEDED: if (hs && seed_ok) state_d = RUN;
      RUN: begin
        if (enable) begin
          if (rep_hit)   state_d = ERR;
          else if (wrap) state_d = RESEED;
        end
      end
      RESEED:   if (hs && seed_ok) state_d = RUN;
      ERR:      state_d = ERR;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    rep_d  = rep_q;
    port_d = port_q;
    rv_d   = 1'b0;
    rr_d   = rr_q;
    rej_d  = 1'b0;
    err_d  = err_q;
    unique case (state_q)
      UNSEEDED, RESEED: begin
        if (hs) begin
          if (seed_ok) begin
            lfsr_d = seed_mix;
            cnt_d  = '0;
            rep_d  = '0;
            rr_d   = 1'b0;
          end else begin
            rej_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (enable) begin
          lfsr_d = s_adv;
          cnt_d  = cnt_q + CW'(1);
          rep_d  = rep_inc;
          // A health failure outranks the budget wrap.
          if (rep_hit) begin
            err_d  = 1'b1;
            port_d = '0;
            rr_d   = 1'b0;
          end else begin
            port_d = bits_adv;
            rv_d   = 1'b1;
            if (wrap) rr_d = 1'b1;
          end
        end
      end
      ERR: begin
        port_d = '0;
        rr_d   = 1'b0;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    seed_ready = (state_q == UNSEEDED) ||
                 (state_q == RESEED);
  end

  assign port_r     = port_q;
  assign r_valid    = rv_q;
  assign reseed_req = rr_q;
  assign seed_rej   = rej_q;
  assign rng_err    = err_q;

endmodule
